fifo_cross_bar: RTL and testbench



---
 rtl/fifo_cross_bar.sv | 136 +++++++++++++
 tb/tb_fifo_cross_bar.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_cross_bar.sv
// Buffered N x M packet switch: one FIFO per input, one round-robin arbiter per output.
// Each word carries its destination output index in its own payload and is forwarded unmodified.
module fifo_cross_bar #(
    parameter int WIDTH              = 64,
    parameter int IN_PORTS           = 8,
    parameter int OUT_PORTS          = 8,
    parameter int FIFO_DEPTH         = 32,
    parameter int IN_ADDR_WIDTH      = 3,
    parameter int OUT_ADDR_WIDTH     = 3,
    parameter int ADDR_OFFSET        = 0,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_PORTS-1:0]           in_valid,
    input  logic [WIDTH*IN_PORTS-1:0]     in_data,
    output logic [IN_PORTS-1:0]           full,
    output logic [OUT_PORTS-1:0]          out_valid,
    output logic [WIDTH*OUT_PORTS-1:0]    out_data,
    input  logic [OUT_PORTS-1:0]          stall,
    output logic [IN_PORTS-1:0]           almost_full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

    // Handshake: a push is taken when in_valid is high and full is low at the edge; an
    // output word is presented for exactly one cycle with out_valid, and stall withholds
    // the grant (the word stays at its FIFO head) rather than holding out_data.

    logic [WIDTH-1:0]          mem        [IN_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr     [IN_PORTS];
    logic [PTR_W-1:0]          wr_ptr     [IN_PORTS];
    logic [CNT_W-1:0]          count      [IN_PORTS];
    logic [IN_ADDR_WIDTH-1:0]  last_grant [OUT_PORTS];
    logic [WIDTH-1:0]          head       [IN_PORTS];
    logic [OUT_ADDR_WIDTH-1:0] dest       [IN_PORTS];
    logic [IN_ADDR_WIDTH-1:0]  grant_idx  [OUT_PORTS];

    // Internal vectors use bit i for port i; only the external ports put port 0 at the MSB.
    logic [IN_PORTS-1:0]  nonempty;
    logic [IN_PORTS-1:0]  push;
    logic [IN_PORTS-1:0]  pop;
    logic [OUT_PORTS-1:0] grant_valid;

    always_comb begin
        head        = '{default: '0};
        dest        = '{default: '0};
        nonempty    = '0;
        push        = '0;
        full        = '0;
        almost_full = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            head[i]                    = mem[i][rd_ptr[i]];
            dest[i]                    = head[i][ADDR_OFFSET +: OUT_ADDR_WIDTH];
            nonempty[i]                = (count[i] != '0);
            full[IN_PORTS-1-i]         = (count[i] == CNT_FULL);
            almost_full[IN_PORTS-1-i]  = (count[i] >= CNT_AFULL);
            push[i]                    = in_valid[IN_PORTS-1-i] && (count[i] != CNT_FULL);
        end
    end

    always_comb begin : arb
        logic [IN_ADDR_WIDTH-1:0] sel;
        sel         = '0;
        pop         = '0;
        grant_valid = '0;
        grant_idx   = '{default: '0};
        // Heads routed to a nonexistent output are dropped so they cannot block the FIFO.
        for (int i = 0; i < IN_PORTS; i++) begin
            if (nonempty[i] && (int'(dest[i]) >= OUT_PORTS)) begin
                pop[i] = 1'b1;
            end
        end
        for (int o = 0; o < OUT_PORTS; o++) begin
            if (!stall[OUT_PORTS-1-o]) begin
                for (int k = 1; k <= IN_PORTS; k++) begin
                    sel = IN_ADDR_WIDTH'((int'(last_grant[o]) + k) % IN_PORTS);
                    if (!grant_valid[o] && nonempty[sel] && (int'(dest[sel]) == o)) begin
                        grant_valid[o] = 1'b1;
                        grant_idx[o]   = sel;
                        pop[sel]       = 1'b1;
                    end
                end
            end
        end
    end

    // Storage is not reset; pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_PORTS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[(IN_PORTS-1-i)*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            for (int o = 0; o < OUT_PORTS; o++) begin
                last_grant[o] <= '0;
            end
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < IN_PORTS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
            for (int o = 0; o < OUT_PORTS; o++) begin
                out_valid[OUT_PORTS-1-o] <= grant_valid[o];
                if (grant_valid[o]) begin
                    out_data[(OUT_PORTS-1-o)*WIDTH +: WIDTH] <= head[grant_idx[o]];
                    last_grant[o]                            <= grant_idx[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_cross_bar.sv
// Self-checking bench for fifo_cross_bar: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the switch.
module tb_fifo_cross_bar;

    localparam int WIDTH              = 64;
    localparam int IN_PORTS           = 8;
    localparam int OUT_PORTS          = 8;
    localparam int FIFO_DEPTH         = 32;
    localparam int IN_ADDR_WIDTH      = 3;
    localparam int OUT_ADDR_WIDTH     = 3;
    localparam int ADDR_OFFSET        = 0;
    localparam int ALMOST_FULL_MARGIN = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [IN_PORTS-1:0]        in_valid;
    logic [WIDTH*IN_PORTS-1:0]  in_data;
    logic [IN_PORTS-1:0]        full;
    logic [OUT_PORTS-1:0]       out_valid;
    logic [WIDTH*OUT_PORTS-1:0] out_data;
    logic [OUT_PORTS-1:0]       stall;
    logic [IN_PORTS-1:0]        almost_full;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per input, last granted input per output.
    logic [WIDTH-1:0]           mq [IN_PORTS][$];
    int                         m_last [OUT_PORTS];
    logic [OUT_PORTS-1:0]       m_ov = '0;
    logic [WIDTH*OUT_PORTS-1:0] m_od = '0;
    logic [IN_PORTS-1:0]        m_full = '0;
    logic [IN_PORTS-1:0]        m_af = '0;
    logic [WIDTH-1:0]           exp_q [$];

    fifo_cross_bar #(
        .WIDTH(WIDTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS), .FIFO_DEPTH(FIFO_DEPTH),
        .IN_ADDR_WIDTH(IN_ADDR_WIDTH), .OUT_ADDR_WIDTH(OUT_ADDR_WIDTH),
        .ADDR_OFFSET(ADDR_OFFSET), .ALMOST_FULL_MARGIN(ALMOST_FULL_MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .full(full),
        .out_valid(out_valid), .out_data(out_data), .stall(stall), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int dest_of(logic [WIDTH-1:0] w);
        return int'(w[ADDR_OFFSET +: OUT_ADDR_WIDTH]);
    endfunction

    function automatic logic [WIDTH-1:0] out_word(int o);
        return out_data[(OUT_PORTS-1-o)*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] make_word(int d, int tag);
        logic [WIDTH-1:0] w;
        w = {$urandom(), $urandom()};
        w[23:8] = 16'(tag);
        w[ADDR_OFFSET +: OUT_ADDR_WIDTH] = OUT_ADDR_WIDTH'(d);
        return w;
    endfunction

    task automatic set_word(int i, logic [WIDTH-1:0] w);
        in_valid[IN_PORTS-1-i] = 1'b1;
        in_data[(IN_PORTS-1-i)*WIDTH +: WIDTH] = w;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_data  = '0;
    endtask

    task automatic model_step();
        logic [IN_PORTS-1:0] pop_m;
        logic [IN_PORTS-1:0] acc;
        bit done;
        int sel;
        if (!rst) begin
            for (int i = 0; i < IN_PORTS; i++) mq[i].delete();
            for (int o = 0; o < OUT_PORTS; o++) m_last[o] = 0;
            m_ov = '0;
            m_od = '0;
        end else begin
            pop_m = '0;
            acc   = '0;
            m_ov  = '0;
            for (int i = 0; i < IN_PORTS; i++) begin
                acc[i] = in_valid[IN_PORTS-1-i] && (mq[i].size() < FIFO_DEPTH);
                if (mq[i].size() > 0 && dest_of(mq[i][0]) >= OUT_PORTS) pop_m[i] = 1'b1;
            end
            for (int o = 0; o < OUT_PORTS; o++) begin
                done = 1'b0;
                if (!stall[OUT_PORTS-1-o]) begin
                    for (int k = 1; k <= IN_PORTS; k++) begin
                        sel = (m_last[o] + k) % IN_PORTS;
                        if (!done && mq[sel].size() > 0 && dest_of(mq[sel][0]) == o) begin
                            done = 1'b1;
                            m_ov[OUT_PORTS-1-o] = 1'b1;
                            m_od[(OUT_PORTS-1-o)*WIDTH +: WIDTH] = mq[sel][0];
                            m_last[o] = sel;
                            pop_m[sel] = 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < IN_PORTS; i++) begin
                if (pop_m[i]) void'(mq[i].pop_front());
                if (acc[i]) mq[i].push_back(in_data[(IN_PORTS-1-i)*WIDTH +: WIDTH]);
            end
        end
        for (int i = 0; i < IN_PORTS; i++) begin
            m_full[IN_PORTS-1-i] = (mq[i].size() == FIFO_DEPTH);
            m_af[IN_PORTS-1-i]   = (mq[i].size() >= FIFO_DEPTH - ALMOST_FULL_MARGIN);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        stall = '0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        stall = '0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < IN_PORTS; i++) set_word(i, make_word(i % OUT_PORTS, c));
            tick();
            checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_out_valid got %h exp 0", out_valid); end
            checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
            checks++; if (full !== '0) begin errors++; $display("FAIL reset_full got %h exp 0", full); end
            checks++; if (almost_full !== '0) begin errors++; $display("FAIL reset_almost_full got %h exp 0", almost_full); end
        end
        rst = 1'b1;
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_push_ignored got %h exp 0", out_valid); end
            checks++; if (full !== '0 || almost_full !== '0) begin errors++; $display("FAIL reset_flags_after got %h/%h exp 0/0", full, almost_full); end
        end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0]           w;
        logic [OUT_PORTS-1:0]       ev;
        logic [WIDTH*OUT_PORTS-1:0] ed;
        do_reset();
        w = make_word(5, 16'h22);
        set_word(2, w);
        tick();
        clear_inputs();
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL single_early got %h exp 0", out_valid); end
        tick();
        ev = '0;
        ev[OUT_PORTS-1-5] = 1'b1;
        ed = '0;
        ed[(OUT_PORTS-1-5)*WIDTH +: WIDTH] = w;
        checks++; if (out_valid !== ev) begin errors++; $display("FAIL single_valid got %h exp %h", out_valid, ev); end
        checks++; if (out_data !== ed) begin errors++; $display("FAIL single_data got %h exp %h", out_data, ed); end
        tick();
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL single_after got %h exp 0", out_valid); end
    endtask

    task automatic test_contention();
        logic [WIDTH-1:0] w [IN_PORTS][2];
        logic [WIDTH-1:0] e;
        do_reset();
        exp_q.delete();
        for (int s = 0; s < 2; s++) begin
            w[0][s] = make_word(4, 16'h0100 + s);
            w[1][s] = make_word(4, 16'h0200 + s);
            w[3][s] = make_word(4, 16'h0400 + s);
            exp_q.push_back(w[1][s]);
            exp_q.push_back(w[3][s]);
            exp_q.push_back(w[0][s]);
        end
        set_word(0, w[0][0]); set_word(1, w[1][0]); set_word(3, w[3][0]);
        tick();
        clear_inputs();
        set_word(0, w[0][1]); set_word(1, w[1][1]); set_word(3, w[3][1]);
        for (int k = 0; k < 6; k++) begin
            tick();
            clear_inputs();
            e = exp_q.pop_front();
            checks++; if (out_valid[OUT_PORTS-1-4] !== 1'b1) begin errors++; $display("FAIL contention_valid[%0d] got %b exp 1", k, out_valid[OUT_PORTS-1-4]); end
            checks++; if (out_word(4) !== e) begin errors++; $display("FAIL contention_word[%0d] got %h exp %h", k, out_word(4), e); end
        end
        tick();
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL contention_drained got %h exp 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] e;
        do_reset();
        exp_q.delete();
        stall[OUT_PORTS-1-4] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = make_word(4, k);
            exp_q.push_back(w);
            clear_inputs();
            set_word(0, w);
            tick();
            checks++; if (out_valid[OUT_PORTS-1-4] !== 1'b0) begin errors++; $display("FAIL stall_held[%0d] got %b exp 0", k, out_valid[OUT_PORTS-1-4]); end
            checks++; if (almost_full[IN_PORTS-1] !== 1'b0) begin errors++; $display("FAIL stall_almost_full[%0d] got %b exp 0", k, almost_full[IN_PORTS-1]); end
        end
        clear_inputs();
        stall = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            e = exp_q.pop_front();
            checks++; if (out_valid[OUT_PORTS-1-4] !== 1'b1) begin errors++; $display("FAIL stall_release_valid[%0d] got %b exp 1", k, out_valid[OUT_PORTS-1-4]); end
            checks++; if (out_word(4) !== e) begin errors++; $display("FAIL stall_release_word[%0d] got %h exp %h", k, out_word(4), e); end
        end
        tick();
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL stall_drained got %h exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] e;
        int n;
        do_reset();
        exp_q.delete();
        stall[OUT_PORTS-1-4] = 1'b1;
        for (int k = 0; k < 34; k++) begin
            w = make_word(4, k);
            if (k < FIFO_DEPTH) exp_q.push_back(w);
            clear_inputs();
            set_word(0, w);
            tick();
            n = (k + 1 < FIFO_DEPTH) ? k + 1 : FIFO_DEPTH;
            checks++; if (full[IN_PORTS-1] !== (n == FIFO_DEPTH)) begin errors++; $display("FAIL overflow_full[%0d] got %b exp %b", k, full[IN_PORTS-1], (n == FIFO_DEPTH)); end
            checks++; if (almost_full[IN_PORTS-1] !== (n >= 30)) begin errors++; $display("FAIL overflow_almost_full[%0d] got %b exp %b", k, almost_full[IN_PORTS-1], (n >= 30)); end
            checks++; if (out_valid !== '0) begin errors++; $display("FAIL overflow_stalled[%0d] got %h exp 0", k, out_valid); end
        end
        clear_inputs();
        stall = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            tick();
            e = exp_q.pop_front();
            checks++; if (out_valid[OUT_PORTS-1-4] !== 1'b1) begin errors++; $display("FAIL overflow_drain_valid[%0d] got %b exp 1", k, out_valid[OUT_PORTS-1-4]); end
            checks++; if (out_word(4) !== e) begin errors++; $display("FAIL overflow_drain_word[%0d] got %h exp %h", k, out_word(4), e); end
            checks++; if (full[IN_PORTS-1] !== 1'b0) begin errors++; $display("FAIL overflow_drain_full[%0d] got %b exp 0", k, full[IN_PORTS-1]); end
        end
        tick();
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL overflow_dropped_words got %h exp 0", out_valid); end
    endtask

    task automatic test_parallel();
        int rot;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            rot = $urandom_range(0, OUT_PORTS - 1);
            clear_inputs();
            for (int i = 0; i < IN_PORTS; i++) set_word(i, make_word((i + rot) % OUT_PORTS, c));
            tick();
            if (c == 0) begin
                checks++; if (out_valid !== '0) begin errors++; $display("FAIL parallel_latency got %h exp 0", out_valid); end
            end else begin
                checks++; if (out_valid !== '1) begin errors++; $display("FAIL parallel_valid[%0d] got %h exp ff", c, out_valid); end
            end
            checks++; if (full !== '0) begin errors++; $display("FAIL parallel_full[%0d] got %h exp 0", c, full); end
            checks++; if (out_data !== m_od) begin errors++; $display("FAIL parallel_data[%0d] got %h exp %h", c, out_data, m_od); end
        end
        clear_inputs();
        tick();
        checks++; if (out_valid !== '1) begin errors++; $display("FAIL parallel_tail got %h exp ff", out_valid); end
        tick();
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL parallel_idle got %h exp 0", out_valid); end
    endtask

    task automatic test_random();
        int hot;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            hot = (c / 100) % 2;
            rst = ($urandom_range(0, 199) != 0);
            clear_inputs();
            for (int i = 0; i < IN_PORTS; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_word(i, make_word(hot ? $urandom_range(0, 1) : $urandom_range(0, OUT_PORTS - 1), c));
            end
            for (int o = 0; o < OUT_PORTS; o++) stall[o] = ($urandom_range(0, 3) == 0);
            tick();
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL random_valid[%0d] got %h exp %h", c, out_valid, m_ov); end
            checks++; if (out_data !== m_od) begin errors++; $display("FAIL random_data[%0d] got %h exp %h", c, out_data, m_od); end
            checks++; if (full !== m_full) begin errors++; $display("FAIL random_full[%0d] got %h exp %h", c, full, m_full); end
            checks++; if (almost_full !== m_af) begin errors++; $display("FAIL random_almost_full[%0d] got %h exp %h", c, almost_full, m_af); end
        end
        rst   = 1'b1;
        stall = '0;
        clear_inputs();
    endtask

    initial begin
        rst   = 1'b0;
        stall = '0;
        clear_inputs();
        for (int o = 0; o < OUT_PORTS; o++) m_last[o] = 0;
        test_reset();
        test_single();
        test_contention();
        test_stall();
        test_overflow();
        test_parallel();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
